// File: rtl/seq_010_tx.sv
// Serial "010" pattern transmitter: sends N non-overlapping 010 patterns,
// each followed by at least two guard '1' bits, with done/aborted status pulses.
module seq_010_tx #(
    parameter int CNT_W = 10,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pat,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] sent_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_GAP  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] glen_q, glen_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    // Next-state, counters and registered-output precomputation
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        glen_d    = glen_q;
        gcnt_d    = gcnt_q;
        cnt_d     = cnt_q;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE, S_FIN: begin
                // Abort beats a simultaneous start while idle; the start is dropped.
                if (start && !abort) begin
                    rem_d   = num_pat;
                    glen_d  = (gap_len < GAP_W'(2)) ? GAP_W'(2) : gap_len;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = (num_pat == {CNT_W{1'b0}}) ? S_FIN : S_B0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_B0: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = S_B1;
                end
            end
            S_B1: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = S_B2;
                end
            end
            S_B2: begin
                rem_d = rem_q - CNT_W'(1);
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = S_GAP;
                    gcnt_d  = glen_q - GAP_W'(1);
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (gcnt_q == {GAP_W{1'b0}}) begin
                    state_d = (rem_q != {CNT_W{1'b0}}) ? S_B0 : S_FIN;
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        x_d    = !((state_d == S_B0) || (state_d == S_B2));
        busy_d = (state_d == S_B0) || (state_d == S_B1) ||
                 (state_d == S_B2) || (state_d == S_GAP);
        done_d = (state_d == S_FIN);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rem_q     <= {CNT_W{1'b0}};
            glen_q    <= GAP_W'(2);
            gcnt_q    <= {GAP_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            x_q       <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            glen_q    <= glen_d;
            gcnt_q    <= gcnt_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign x_out      = x_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign sent_count = cnt_q;

endmodule
